fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter: RESET_PC, 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 SHALL provide port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL provide port: pc_s  input  2  next-PC select from control: 00 PC+4, 01 jump, 10 branch, 11 reserved.
REQ-005 SHALL provide port: hold  input  1  when high, freezes the unit in EXEC.
REQ-006 SHALL provide port: im_req  output  1  instruction memory read request.
REQ-007 SHALL provide port: im_addr  output  32  instruction memory byte address.
REQ-008 SHALL provide port: im_ack  input  1  memory read data valid this cycle.
REQ-009 SHALL provide port: im_rdata  input  32  memory read data.
REQ-010 SHALL provide port: pc  output  32  address of the instruction currently held in ir.
REQ-011 SHALL provide port: ir  output  32  instruction register; ir[31:26] and ir[5:0] drive control decode.
REQ-012 SHALL provide port: ir_valid  output  1  ir holds an instruction being executed this cycle.
REQ-013 SHALL provide port: instr_count  output  32  number of retired instructions.

Function
REQ-014 SHALL implement a two-state FSM: FETCH and EXEC; state after reset is FETCH.
REQ-015 SHALL drive im_req=1 and im_addr=pc in FETCH; im_req=0 in EXEC; im_addr=pc at all times.
REQ-016 SHALL, in FETCH on a rising edge with im_ack=1, load ir<=im_rdata and move to EXEC; with im_ack=0, stay in FETCH with pc and ir unchanged.
REQ-017 SHALL ignore im_ack and im_rdata whenever state is EXEC.
REQ-018 SHALL drive ir_valid=1 exactly when state is EXEC (combinational from state).
REQ-019 SHALL, in EXEC with hold=1, keep state, pc, ir and instr_count unchanged.
REQ-020 SHALL, in EXEC with hold=0 on a rising edge, load pc<=next_pc, increment instr_count by 1, and return to FETCH.
REQ-021 SHALL compute pc_plus4 = pc + 4, modulo 2^32.
REQ-022 SHALL compute branch target = pc_plus4 + {{14{ir[15]}}, ir[15:0], 2'b00}, modulo 2^32.
REQ-023 SHALL compute jump target = {pc_plus4[31:28], ir[25:0], 2'b00}.
REQ-024 SHALL select next_pc per pc_s: 00 pc_plus4, 01 jump target, 10 branch target, 11 pc_plus4.
REQ-025 SHALL sample pc_s only on the EXEC-to-FETCH edge; pc_s in other cycles has no effect.
REQ-026 SHALL wrap instr_count from 32'hFFFF_FFFF to 0; pc wraps from 32'hFFFF_FFFC to 0 on PC+4.
REQ-027 SHALL make the minimum instruction period 2 cycles: one FETCH cycle with im_ack=1, then one EXEC cycle with hold=0.

Reset
REQ-028 SHALL, while rst=1 and independent of clk, force state=FETCH, pc=RESET_PC, ir=0, instr_count=0.
REQ-029 SHALL, while rst=1, force im_req=0; im_req follows the FSM from the first rising edge after rst falls.
REQ-030 SHALL, when reset asserts mid-fetch or mid-EXEC, abandon the in-flight fetch and restart at RESET_PC after release, without retiring the instruction.

Verification
REQ-031 SHALL cover reset.
- Stimulus: rst=1 for 3 cycles, then release.
- Response while rst=1: pc=0, ir=0, ir_valid=0, im_req=0, instr_count=0.
- Response after release: im_req=1, im_addr=0.
REQ-032 SHALL cover sequential fetch.
- Stimulus: at pc=0, im_ack=1 with im_rdata=32'h8C080004, then pc_s=00 with hold=0.
- Response: ir=32'h8C080004 with ir_valid=1 for 1 cycle, then im_addr=32'h4, instr_count=1.
REQ-033 SHALL cover branch taken.
- Stimulus: pc=32'h10, ir=32'h1108FFFE, pc_s=10 in EXEC.
- Response: next im_addr=32'h0000000C.
REQ-034 SHALL cover jump.
- Stimulus: pc=32'h20, ir=32'h08000040, pc_s=01 in EXEC.
- Response: next im_addr=32'h00000100.
REQ-035 SHALL cover wait and hold.
- Stimulus: im_ack=0 for 3 cycles; then, in EXEC, hold=1 for 2 cycles.
- Response during im_ack=0: im_req stays 1, pc unchanged.
- Response during hold=1: ir_valid stays 1, pc and instr_count unchanged.
- Response after hold falls: pc advances once.
REQ-036 SHALL cover reset mid-operation.
- Stimulus: rst pulsed during FETCH with im_ack=0 at pc=32'h40.
- Response: pc=0 and instr_count=0 immediately; after release, im_addr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: two-state FETCH/EXEC instruction fetch with PC sequencing,
// branch/jump target generation and a retired-instruction counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_s,
  input  logic        hold,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [31:0] instr_count
);
  typedef enum logic {FETCH, EXEC} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, cnt_q, cnt_d;
  logic [31:0] pc_plus4, br_tgt, j_tgt, next_pc;
  logic        im_req_q, fetch_done, retire;
  always_comb begin
    pc_plus4   = pc_q + 32'd4;
    br_tgt     = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    j_tgt      = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    next_pc    = pc_s == 2'b01 ? j_tgt : pc_s == 2'b10 ? br_tgt : pc_plus4;
    fetch_done = state_q == FETCH && im_ack;
    retire     = state_q == EXEC && !hold;
    state_d    = fetch_done ? EXEC : retire ? FETCH : state_q;
    ir_d       = fetch_done ? im_rdata : ir_q;
    pc_d       = retire ? next_pc : pc_q;
    cnt_d      = retire ? cnt_q + 32'd1 : cnt_q;
  end
  // im_req is registered so it stays low through reset and rises on the first edge after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      cnt_q    <= '0;
      im_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      im_req_q <= state_d == FETCH;
    end
  end
  assign im_req      = im_req_q;
  assign im_addr     = pc_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign ir_valid    = state_q == EXEC;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; the bench plays instruction memory and
// queues the fetch address it expects after every retire.
module tb_fetch_unit;
  logic        clk = 1'b0, rst = 1'b1, hold = 1'b0, im_ack = 1'b0;
  logic [1:0]  pc_s = 2'b00;
  logic [31:0] im_rdata = '0;
  logic        im_req, ir_valid;
  logic [31:0] im_addr, pc, ir, instr_count;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc = '0, m_ir = '0, m_cnt = '0;
  int          vectors = 0, miscompares = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_s(pc_s), .hold(hold),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
    .pc(pc), .ir(ir), .ir_valid(ir_valid), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] i, input logic [1:0] s);
    logic [31:0] p4;
    p4 = p + 32'd4;
    return s == 2'b01 ? {p4[31:28], i[25:0], 2'b00} :
           s == 2'b10 ? p4 + {{14{i[15]}}, i[15:0], 2'b00} : p4;
  endfunction

  task automatic fetch(input logic [31:0] instr, input int waits);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      e = m_pc;
    end else e = exp_q.pop_front();
    chk("fetch_req", im_req, 1);
    chk("fetch_addr", im_addr, e);
    repeat (waits) begin
      im_ack = 1'b0;
      im_rdata = $urandom;
      hold = 1'($urandom);
      @(posedge clk); #1;
      chk("wait_req", im_req, 1);
      chk("wait_pc", pc, e);
      chk("wait_valid", ir_valid, 0);
    end
    im_ack = 1'b1;
    im_rdata = instr;
    @(posedge clk); #1;
    im_ack = 1'b0;
    im_rdata = $urandom;
    m_ir = instr;
    chk("ir", ir, instr);
    chk("ir_valid", ir_valid, 1);
    chk("exec_req", im_req, 0);
  endtask

  task automatic exec(input logic [1:0] sel, input int holds);
    logic [31:0] nxt;
    repeat (holds) begin
      hold = 1'b1;
      pc_s = 2'($urandom);
      im_ack = 1'b1;
      im_rdata = $urandom;
      @(posedge clk); #1;
      chk("hold_valid", ir_valid, 1);
      chk("hold_pc", pc, m_pc);
      chk("hold_ir", ir, m_ir);
      chk("hold_cnt", instr_count, m_cnt);
    end
    hold = 1'b0;
    pc_s = sel;
    im_ack = 1'b1;
    im_rdata = $urandom;
    nxt = model_next(m_pc, m_ir, sel);
    exp_q.push_back(nxt);
    @(posedge clk); #1;
    im_ack = 1'b0;
    pc_s = 2'($urandom);
    hold = 1'($urandom);
    m_pc = nxt;
    m_cnt = m_cnt + 32'd1;
    chk("retire_cnt", instr_count, m_cnt);
    chk("retire_valid", ir_valid, 0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rel_req_low", im_req, 0);
    @(posedge clk); #1;
    chk("rel_req", im_req, 1);
    chk("rel_addr", im_addr, 32'h0);
    m_pc = '0;
    m_cnt = '0;
    exp_q.delete();
    exp_q.push_back(32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_req", im_req, 0);
    chk("rst_cnt", instr_count, 0);
    release_reset();
    fetch(32'h8C080004, 0);
    exec(2'b00, 0);
    chk("seq_addr", im_addr, 32'h4);
    chk("seq_cnt", instr_count, 32'd1);
    for (int i = 0; i < 3; i++) begin
      fetch($urandom, 0);
      exec(2'b00, 0);
    end
    fetch(32'h1108FFFE, 0);
    exec(2'b10, 0);
    chk("br_addr", im_addr, 32'h0000000C);
    for (int i = 0; i < 5; i++) begin
      fetch($urandom, 0);
      exec(i == 2 ? 2'b11 : 2'b00, 0);
    end
    chk("pre_jmp_pc", pc, 32'h20);
    fetch(32'h08000040, 0);
    exec(2'b01, 0);
    chk("jmp_addr", im_addr, 32'h00000100);
    fetch(32'h08000010, 3);
    exec(2'b01, 2);
    chk("hold_adv", pc, 32'h40);
    im_ack = 1'b0;
    @(posedge clk); #1;
    chk("mid_wait_pc", pc, 32'h40);
    #2 rst = 1'b1;
    #1;
    chk("midf_pc", pc, 0);
    chk("midf_cnt", instr_count, 0);
    chk("midf_req", im_req, 0);
    release_reset();
    fetch(32'h1000FFFE, 0);
    exec(2'b10, 0);
    chk("br_neg", im_addr, 32'hFFFFFFFC);
    fetch($urandom, 0);
    exec(2'b00, 1);
    chk("pc_wrap", im_addr, 32'h0);
    fetch($urandom, 0);
    #2 rst = 1'b1;
    #1;
    chk("mide_cnt", instr_count, 0);
    chk("mide_valid", ir_valid, 0);
    chk("mide_ir", ir, 0);
    release_reset();
    fetch(32'h00000000, 1);
    exec(2'b00, 0);
    chk("final_addr", im_addr, 32'h4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
